serial_cmd_tx: RTL and testbench

//  Transmit end of the 3-wire serial command link (en / wr / data) used by the
//  poc-verification designs. Accepts parallel read/write commands on a

---
 rtl/serial_link_pkg.sv | 21 ++
 rtl/serial_shift_out.sv | 26 ++
 rtl/serial_cmd_tx.sv | 144 ++++++++++++++
 tb/tb_serial_cmd_tx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared types and defaults for the 3-wire serial command link (en / wr / data).
// SERIAL_TX_PARITY_EN adds one even-parity bit to every frame.
package serial_link_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, PARITY, GAP} tx_state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Bits on the line for one frame at the default widths
  function automatic int frame_len(input logic wr);
    return DEF_ADDR_W + (wr ? DEF_DATA_W : 0) + PAR_BITS;
  endfunction

endpackage

// File: rtl/serial_shift_out.sv
// Loadable MSB-first shift register; zeros are shifted in at the LSB end.
module serial_shift_out #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sr <= '0;
    else if (load)
      sr <= din;
    else if (shift)
      sr <= {sr[W-2:0], 1'b0};
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/serial_cmd_tx.sv
// Serialises valid/ready read/write commands onto en/wr/data, MSB first, then idles IDLE_GAP cycles.
// SERIAL_TX_PARITY_EN appends an even-parity bit covering all address and write-data bits.
module serial_cmd_tx
  import serial_link_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              en,
  output logic              wr,
  output logic              data,
  output logic              busy,
  output logic              frame_done
);

  localparam int SR_W  = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(SR_W + 1);

  tx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             shift;
  logic             sr_msb;
  logic [SR_W-1:0]  load_val;
  logic             addr_last;
  logic             data_last;
  logic             frame_end;
`ifdef SERIAL_TX_PARITY_EN
  logic             par;
`endif

  assign cmd_ready = (state == IDLE) && !rst;
  assign load      = cmd_valid && cmd_ready;
  assign shift     = (state == ADDR) || (state == DATA);
  // The first address bit goes straight to the data register, so the shifter holds the remainder
  assign load_val  = {cmd_addr[ADDR_W-2:0], cmd_wdata, 1'b0};

  assign addr_last = (state == ADDR) && (cnt == CNT_W'(ADDR_W - 1));
  assign data_last = (state == DATA) && (cnt == CNT_W'(DATA_W - 1));
`ifdef SERIAL_TX_PARITY_EN
  assign frame_end = (state == PARITY);
`else
  assign frame_end = (addr_last && !wr) || data_last;
`endif

  serial_shift_out #(.W(SR_W)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (load_val),
    .msb   (sr_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      en         <= 1'b0;
      wr         <= 1'b0;
      data       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (frame_end) begin
        en         <= 1'b0;
        wr         <= 1'b0;
        data       <= 1'b0;
        frame_done <= 1'b1;
        cnt        <= '0;
        if (IDLE_GAP == 0) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          state <= GAP;
        end
      end else begin
        case (state)
          IDLE: begin
            if (load) begin
              state <= ADDR;
              cnt   <= '0;
              en    <= 1'b1;
              wr    <= cmd_wr;
              data  <= cmd_addr[ADDR_W-1];
              busy  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
              par   <= (^cmd_addr) ^ (cmd_wr & (^cmd_wdata));
`endif
            end
          end
          ADDR: begin
            cnt  <= cnt + 1'b1;
            data <= sr_msb;
            if (addr_last) begin
              cnt   <= '0;
              state <= DATA;
`ifdef SERIAL_TX_PARITY_EN
              if (!wr) begin
                state <= PARITY;
                data  <= par;
              end
`endif
            end
          end
          DATA: begin
            cnt  <= cnt + 1'b1;
            data <= sr_msb;
`ifdef SERIAL_TX_PARITY_EN
            if (data_last) begin
              cnt   <= '0;
              state <= PARITY;
              data  <= par;
            end
`endif
          end
          GAP: begin
            if (cnt == CNT_W'(IDLE_GAP - 1)) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_cmd_tx.sv
// Directed bench for serial_cmd_tx at ADDR_W=8, DATA_W=8, IDLE_GAP=2, parity disabled.
module tb_serial_cmd_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_wr = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       en, wr, data, busy, frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_cmd_tx #(.ADDR_W(8), .DATA_W(8), .IDLE_GAP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .en         (en),
    .wr         (wr),
    .data       (data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for cmd_ready, presents one command for one cycle; returns at the first frame cycle
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_wr    = w;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Collects bits while en is high; returns at the first en-low negedge
  task automatic capture(input logic exp_wr, output int n, output logic [31:0] bits, output logic wr_bad);
    n = 0;
    bits = '0;
    wr_bad = 1'b0;
    for (int i = 0; i < 40 && en; i++) begin
      bits = {bits[30:0], data};
      if (wr !== exp_wr || busy !== 1'b1) wr_bad = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          n, gap, rdy;
    logic [31:0] bits;
    logic        wr_bad;
    logic        seen;

    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_en",    {31'd0, en},         32'd0);
    chk("rst_wr",    {31'd0, wr},         32'd0);
    chk("rst_data",  {31'd0, data},       32'd0);
    chk("rst_busy",  {31'd0, busy},       32'd0);
    chk("rst_done",  {31'd0, frame_done}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready},  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);

    // Write frame: first bit right after the accept edge
    send(1'b1, 8'hA5, 8'h3C);
    chk("wr_first_en", {31'd0, en}, 32'd1);
    capture(1'b1, n, bits, wr_bad);
    chk("wr_len",    n,                 32'd16);
    chk("wr_bits",   bits,              32'h0000_A53C);
    chk("wr_const",  {31'd0, wr_bad},   32'd0);
    chk("wr_done",   {31'd0, frame_done}, 32'd1);
    chk("wr_data0",  {31'd0, data},     32'd0);
    @(negedge clk);
    chk("wr_done_1cyc", {31'd0, frame_done}, 32'd0);
    chk("gap_busy",  {31'd0, busy},      32'd1);
    chk("gap_ready", {31'd0, cmd_ready}, 32'd0);

    // Read frame: write data must never appear on the line
    send(1'b0, 8'h0F, 8'hFF);
    capture(1'b0, n, bits, wr_bad);
    chk("rd_len",   n,                   32'd8);
    chk("rd_bits",  bits,                32'h0000_000F);
    chk("rd_const", {31'd0, wr_bad},     32'd0);
    chk("rd_done",  {31'd0, frame_done}, 32'd1);

    // Back-to-back writes with cmd_valid held
    send(1'b1, 8'h12, 8'h34);
    cmd_valid = 1'b1;
    cmd_addr  = 8'hC3;
    cmd_wdata = 8'h81;
    capture(1'b1, n, bits, wr_bad);
    chk("b2b_len1",  n,    32'd16);
    chk("b2b_bits1", bits, 32'h0000_1234);
    gap = 0;
    rdy = 0;
    for (int i = 0; i < 20 && !en; i++) begin
      gap++;
      if (cmd_ready) rdy++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_gap",   gap, 32'd3);
    chk("b2b_ready", rdy, 32'd1);
    capture(1'b1, n, bits, wr_bad);
    chk("b2b_len2",  n,    32'd16);
    chk("b2b_bits2", bits, 32'h0000_C381);

    // Reset during bit index 5 of 0xA5 (a 1 on the line)
    send(1'b1, 8'hA5, 8'h3C);
    repeat (5) @(negedge clk);
    chk("pre_rst_data", {31'd0, data}, 32'd1);
    chk("pre_rst_wr",   {31'd0, wr},   32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_en",    {31'd0, en},        32'd0);
    chk("mid_rst_wr",    {31'd0, wr},        32'd0);
    chk("mid_rst_data",  {31'd0, data},      32'd0);
    chk("mid_rst_busy",  {31'd0, busy},      32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en || frame_done) seen = 1'b1;
    end
    chk("post_rst_quiet", {31'd0, seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
